// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared definitions for the pipeline sequencing controller: FSM state encoding,
// the halt opcode and the NOP instruction word.
package pipe_stall_ctrl_pkg;

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_STALL = 2'd1,
        S_FLUSH = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    // HLT is the top opcode slot of the 16-bit ISA opcode map.
    localparam logic [3:0]  OP_HLT = 4'hF;
    localparam logic [15:0] NOP    = 16'd0;

    function automatic logic is_halt(input logic valid, input logic [3:0] opcode);
        return valid && (opcode == OP_HLT);
    endfunction

endpackage

// File: rtl/pipe_stall_ctrl_if.sv
// Handshake bundle between the hazard/branch sources and the pipeline register
// enables. Performance counter signals exist only when STALL_PERF_EN is defined.
interface pipe_stall_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             hazard;
    logic             id_valid;
    logic [3:0]       id_opcode;
    logic             ex_redirect;
    logic             resume;
    logic             pc_we;
    logic             ifid_we;
    logic             ifid_flush;
    logic             idex_bubble;
    logic             stalled;
    logic             halted;
    logic             stall_err;
`ifdef STALL_PERF_EN
    logic [CNT_W-1:0] perf_stall_cnt;
    logic [CNT_W-1:0] perf_flush_cnt;
`endif

    modport master (
        output hazard, id_valid, id_opcode, ex_redirect, resume,
        input  pc_we, ifid_we, ifid_flush, idex_bubble, stalled, halted, stall_err
`ifdef STALL_PERF_EN
        , input perf_stall_cnt, perf_flush_cnt
`endif
    );

    modport slave (
        input  hazard, id_valid, id_opcode, ex_redirect, resume,
        output pc_we, ifid_we, ifid_flush, idex_bubble, stalled, halted, stall_err
`ifdef STALL_PERF_EN
        , output perf_stall_cnt, perf_flush_cnt
`endif
    );

endinterface

// File: rtl/pipe_stall_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear and asynchronous active-low reset.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Freezes, bubbles and squashes the PC, IF/ID and ID/EX stages of the 5-stage CPU.
// Optional performance counters are built when STALL_PERF_EN is defined.
module pipe_stall_ctrl
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int MAX_STALL = 3,
    parameter int CNT_W     = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    pipe_stall_ctrl_if.slave        bus
);

    localparam int SW = (MAX_STALL < 2) ? 1 : $clog2(MAX_STALL + 1);
    localparam logic [SW-1:0] STALL_LIMIT = SW'(MAX_STALL);

    state_t        state;
    logic [SW-1:0] stall_cnt;
    logic          stall_err;
    logic          stalled;
    logic          halted;

    logic          halt_dec;
    logic          redirect_act;
    logic          hazard_hold;
    logic          pc_we;
    logic          ifid_we;
    logic          ifid_flush;
    logic          idex_bubble;

    assign halt_dec     = is_halt(bus.id_valid, bus.id_opcode);
    assign redirect_act = bus.ex_redirect && (state != S_HALT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_RUN;
            stall_cnt <= '0;
            stall_err <= 1'b0;
            stalled   <= 1'b0;
            halted    <= 1'b0;
        end else begin
            unique case (state)
                S_RUN: begin
                    if (bus.ex_redirect) begin
                        state <= S_FLUSH;
                    end else if (halt_dec) begin
                        state  <= S_HALT;
                        halted <= 1'b1;
                    end else if (bus.hazard && bus.id_valid) begin
                        state     <= S_STALL;
                        stall_cnt <= SW'(1);
                        stalled   <= 1'b1;
                    end
                end
                S_STALL: begin
                    if (bus.ex_redirect) begin
                        state     <= S_FLUSH;
                        stall_cnt <= '0;
                        stalled   <= 1'b0;
                    end else if (!bus.hazard) begin
                        state     <= S_RUN;
                        stall_cnt <= '0;
                        stalled   <= 1'b0;
                    end else if (stall_cnt == STALL_LIMIT) begin
                        // Forced release: a dependency that outlives the detector
                        // history would otherwise deadlock the pipeline.
                        state     <= S_RUN;
                        stall_cnt <= '0;
                        stalled   <= 1'b0;
                        stall_err <= 1'b1;
                    end else begin
                        stall_cnt <= stall_cnt + SW'(1);
                    end
                end
                S_FLUSH: begin
                    if (!bus.ex_redirect) begin
                        state <= S_RUN;
                    end
                end
                S_HALT: begin
                    if (bus.resume) begin
                        state  <= S_RUN;
                        halted <= 1'b0;
                    end
                end
                default: begin
                    state <= S_RUN;
                end
            endcase
        end
    end

    // Zero-latency control: enables react to hazard/redirect in the same cycle.
    always_comb begin
        pc_we       = 1'b1;
        ifid_we     = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        hazard_hold = 1'b0;
        if (rst) begin
            if (state == S_HALT) begin
                pc_we       = 1'b0;
                ifid_we     = 1'b0;
                idex_bubble = 1'b1;
            end else if (redirect_act) begin
                ifid_we     = 1'b0;
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
            end else if (state == S_FLUSH) begin
                ifid_flush  = 1'b1;
            end else if (state == S_STALL) begin
                hazard_hold = bus.hazard && (stall_cnt != STALL_LIMIT);
            end else begin
                hazard_hold = !halt_dec && bus.hazard && bus.id_valid;
            end

            if (hazard_hold) begin
                pc_we       = 1'b0;
                ifid_we     = 1'b0;
                idex_bubble = 1'b1;
            end
        end
    end

    assign bus.pc_we       = pc_we;
    assign bus.ifid_we     = ifid_we;
    assign bus.ifid_flush  = ifid_flush;
    assign bus.idex_bubble = idex_bubble;
    assign bus.stalled     = stalled;
    assign bus.halted      = halted;
    assign bus.stall_err   = stall_err;

`ifdef STALL_PERF_EN
    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (hazard_hold),
        .clr (1'b0),
        .cnt (bus.perf_stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .inc (redirect_act),
        .clr (1'b0),
        .cnt (bus.perf_flush_cnt)
    );
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl: reset, stall limit, redirect, halt/resume,
// priority, and (with STALL_PERF_EN) the performance counters.
module tb_pipe_stall_ctrl;
    import pipe_stall_ctrl_pkg::*;

    logic clk;
    logic rst;
    int   total;
    int   passed;

    pipe_stall_ctrl_if #(.CNT_W(16)) bus ();

    pipe_stall_ctrl #(.MAX_STALL(3), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

`ifdef STALL_PERF_EN
    logic       sc_inc;
    logic       sc_clr;
    logic [1:0] sc_cnt;

    sat_counter #(.W(2)) u_sc2 (
        .clk (clk),
        .rst (rst),
        .inc (sc_inc),
        .clr (sc_clr),
        .cnt (sc_cnt)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Outputs packed as {pc_we, ifid_we, ifid_flush, idex_bubble}.
    task automatic chk_out(input string tag, input logic [3:0] exp);
        chk({tag, "_out"}, {28'd0, bus.pc_we, bus.ifid_we, bus.ifid_flush, bus.idex_bubble},
            {28'd0, exp});
    endtask

    // Status packed as {stalled, halted, stall_err}.
    task automatic chk_st(input string tag, input logic [2:0] exp);
        chk({tag, "_st"}, {29'd0, bus.stalled, bus.halted, bus.stall_err}, {29'd0, exp});
    endtask

    task automatic cyc(input logic hz, input logic vld, input logic [3:0] op,
                       input logic redir, input logic res);
        @(negedge clk);
        bus.hazard      = hz;
        bus.id_valid    = vld;
        bus.id_opcode   = op;
        bus.ex_redirect = redir;
        bus.resume      = res;
        #1;
    endtask

    initial begin
        total  = 0;
        passed = 0;
        rst    = 1'b0;
        bus.hazard      = 1'b1;
        bus.id_valid    = 1'b1;
        bus.id_opcode   = 4'h1;
        bus.ex_redirect = 1'b0;
        bus.resume      = 1'b0;
`ifdef STALL_PERF_EN
        sc_inc = 1'b0;
        sc_clr = 1'b0;
`endif
        #2;
        chk_out("rst_hz", 4'b1100);
        chk_st("rst_hz", 3'b000);
        @(posedge clk);
        #1;
        chk_out("rst_hz_clk", 4'b1100);

        // Release reset with hazard high for two cycles.
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk_out("hz2_c1", 4'b0001);
        chk_st("hz2_c1", 3'b000);
        cyc(1, 1, 4'h1, 0, 0);
        chk_out("hz2_c2", 4'b0001);
        chk_st("hz2_c2", 3'b100);
        cyc(0, 1, 4'h1, 0, 0);
        chk_out("hz2_c3", 4'b1100);
        chk_st("hz2_c3", 3'b100);
        cyc(0, 1, 4'h1, 0, 0);
        chk_out("hz2_c4", 4'b1100);
        chk_st("hz2_c4", 3'b000);

        // Hazard held five cycles: three stalls, forced release, stall again.
        cyc(1, 1, 4'h1, 0, 0);
        chk_out("max_c1", 4'b0001);
        cyc(1, 1, 4'h1, 0, 0);
        chk_out("max_c2", 4'b0001);
        chk_st("max_c2", 3'b100);
        cyc(1, 1, 4'h1, 0, 0);
        chk_out("max_c3", 4'b0001);
        cyc(1, 1, 4'h1, 0, 0);
        chk_out("max_c4", 4'b1100);
        chk_st("max_c4", 3'b100);
        cyc(1, 1, 4'h1, 0, 0);
        chk_out("max_c5", 4'b0001);
        chk_st("max_c5", 3'b001);
        cyc(0, 1, 4'h1, 0, 0);
        chk_out("max_c6", 4'b1100);
        chk_st("max_c6", 3'b101);
        cyc(0, 1, 4'h1, 0, 0);
        chk_st("max_c7", 3'b001);

        // Hazard in RUN with id_valid low is ignored.
        cyc(1, 0, 4'h1, 0, 0);
        chk_out("hz_novld", 4'b1100);
        cyc(0, 1, 4'h1, 0, 0);
        chk_st("hz_novld", 3'b001);

        // Redirect in the second stall cycle.
        cyc(1, 1, 4'h1, 0, 0);
        chk_out("rd_c1", 4'b0001);
        cyc(1, 1, 4'h1, 1, 0);
        chk_out("rd_c2", 4'b1011);
        chk_st("rd_c2", 3'b101);
        cyc(0, 1, 4'h1, 0, 0);
        chk_out("rd_c3", 4'b1110);
        chk_st("rd_c3", 3'b001);
        cyc(0, 1, 4'h1, 0, 0);
        chk_out("rd_c4", 4'b1100);

        // Back-to-back redirects keep FLUSH.
        cyc(0, 1, 4'h1, 1, 0);
        chk_out("rr_c1", 4'b1011);
        cyc(0, 1, 4'h1, 1, 0);
        chk_out("rr_c2", 4'b1011);
        cyc(0, 1, 4'h1, 0, 0);
        chk_out("rr_c3", 4'b1110);
        cyc(0, 1, 4'h1, 0, 0);
        chk_out("rr_c4", 4'b1100);

        // HLT opcode with id_valid low does not halt.
        cyc(0, 0, OP_HLT, 0, 0);
        chk_out("hlt_novld", 4'b1100);
        cyc(0, 1, 4'h1, 0, 0);
        chk_st("hlt_novld", 3'b001);

        // HLT decode, redirect ignored in HALT, resume.
        cyc(0, 1, OP_HLT, 0, 0);
        chk_out("hlt_c1", 4'b1100);
        chk_st("hlt_c1", 3'b001);
        cyc(0, 1, 4'h1, 0, 0);
        chk_out("hlt_c2", 4'b0001);
        chk_st("hlt_c2", 3'b011);
        cyc(0, 1, 4'h1, 1, 0);
        chk_out("hlt_redir", 4'b0001);
        cyc(0, 1, 4'h1, 0, 0);
        chk_st("hlt_redir", 3'b011);
        cyc(0, 1, 4'h1, 0, 1);
        chk_out("hlt_res", 4'b0001);
        cyc(0, 1, 4'h1, 0, 0);
        chk_out("hlt_run", 4'b1100);
        chk_st("hlt_run", 3'b001);

        // Hazard, HLT and redirect together: flush wins.
        cyc(1, 1, OP_HLT, 1, 0);
        chk_out("pri_c1", 4'b1011);
        cyc(0, 1, 4'h1, 0, 0);
        chk_out("pri_c2", 4'b1110);
        chk_st("pri_c2", 3'b001);
        cyc(0, 1, 4'h1, 0, 0);
        chk_out("pri_c3", 4'b1100);
        chk_st("pri_c3", 3'b001);

        // Asynchronous reset while halted clears everything immediately.
        cyc(0, 1, OP_HLT, 0, 0);
        cyc(1, 1, 4'h1, 0, 0);
        chk_st("pre_arst", 3'b011);
        rst = 1'b0;
        #1;
        chk_st("arst", 3'b000);
        chk_out("arst", 4'b1100);
        @(negedge clk);
        rst = 1'b1;
        bus.hazard = 1'b0;
        #1;
        chk_out("arst_rel", 4'b1100);

`ifdef STALL_PERF_EN
        chk("perf_rst_stall", {16'd0, bus.perf_stall_cnt}, 32'd0);
        chk("perf_rst_flush", {16'd0, bus.perf_flush_cnt}, 32'd0);
        cyc(1, 1, 4'h1, 0, 0);
        cyc(1, 1, 4'h1, 0, 0);
        cyc(1, 1, 4'h1, 0, 0);
        cyc(0, 1, 4'h1, 0, 0);
        cyc(1, 1, 4'h1, 0, 0);
        cyc(1, 1, 4'h1, 1, 0);
        cyc(0, 1, 4'h1, 1, 0);
        cyc(0, 1, 4'h1, 0, 0);
        cyc(0, 1, 4'h1, 0, 0);
        chk("perf_stall", {16'd0, bus.perf_stall_cnt}, 32'd4);
        chk("perf_flush", {16'd0, bus.perf_flush_cnt}, 32'd2);

        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            sc_inc = 1'b1;
        end
        @(negedge clk);
        sc_inc = 1'b0;
        #1;
        chk("sat2", {30'd0, sc_cnt}, 32'd3);
        sc_clr = 1'b1;
        @(negedge clk);
        sc_clr = 1'b0;
        #1;
        chk("sat2_clr", {30'd0, sc_cnt}, 32'd0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
